golden_nonce_collector: RTL and testbench
=========================================

Name: golden_nonce_collector

Overview:
- Sits directly downstream of the fpgaminer_top miner core. It watches the miner's 32-bit golden_nonce output and captures every new nonzero value, together with the miner's running nonce at capture time.
- Captured results are buffered in a small FIFO and presented to a host/reporting stage over a valid/ready handshake.
- Maintains a found counter, a saturating drop counter and a sticky overflow flag, so benchmark runs can report results without stalling the miner.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- NONCE_W, 32, width of golden_nonce, nonce and payload fields.
- CNT_W, 16, width of found_count and drop_count.

Ports:
- clk  input  1  miner clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- golden_nonce  input  NONCE_W  miner result; holds its value until the next find.
- nonce  input  NONCE_W  miner's current nonce counter, sampled alongside the capture.
- clear  input  1  synchronous; zeroes the counters and overflow flag and empties the FIFO.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_golden  output  NONCE_W  head golden nonce.
- out_nonce  output  NONCE_W  head sampled nonce.
- out_seq  output  CNT_W  head sequence number (found_count value at capture).
- found_count  output  CNT_W  number of new finds detected; wraps modulo 2^CNT_W.
- drop_count  output  CNT_W  finds lost to a full FIFO; saturates at all-ones.
- overflow  output  1  sticky; set on the first drop.

Behaviour:
- Reset (reset_n low, asynchronous): last_seen=0, FIFO empty, out_valid=0, out_golden/out_nonce/out_seq=0, found_count=0, drop_count=0, overflow=0. All state held while reset is low. Reset mid-transfer discards all buffered entries.
- Detection:
  - new_find = (golden_nonce != 0) && (golden_nonce != last_seen).
  - last_seen <= golden_nonce on every clock edge, so a 0 -> X transition or an X -> Y change each count once.
  - A steady value is captured once only.
- On a new_find edge: push {golden_nonce, nonce, found_count} and increment found_count (wrapping), whether or not the push succeeds.
- Push succeeds if the FIFO is not full, or if it is full and a pop occurs on the same edge.
- Otherwise the find is dropped:
  - drop_count increments (saturating).
  - overflow is set.
  - The FIFO is unchanged.
- Pop: out_valid && out_ready on a rising edge. The head advances, and the outputs show the next entry on the following cycle, or out_valid=0 if the FIFO is now empty.
- Latency: golden_nonce change sampled at edge N -> out_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty. Back-to-back finds on consecutive cycles are each captured.
- Simultaneous push and pop:
  - When empty: the push is stored, and the head becomes valid next cycle.
  - Otherwise: occupancy is unchanged.
- Output stability: out_* stay stable while out_valid && !out_ready. out_valid never deasserts without a pop, except on clear or reset.
- clear:
  - FIFO emptied, found_count=0, drop_count=0, overflow=0, out_valid=0 on the next edge.
  - last_seen still updates from golden_nonce.
  - A new_find on the same edge as clear is discarded and not counted.
- Pointers are log2(DEPTH)+1 bits wide. Full and empty are derived from the MSB/index compare. Wrap-around is natural modulo 2*DEPTH.
- Outputs are registered from the FIFO head; there is no combinational path from golden_nonce to out_*.

Decomposition:
- Package gnc_pkg holds:
  - NONCE_W default.
  - The entry typedef struct {golden, nonce, seq}.
  - The helper function clog2 for pointer width.
- Sub-module nonce_fifo:
  - Generic synchronous FIFO of entry_t with DEPTH.
  - Ports: push/pop/flush, full/empty, and registered head.
  - Same clk and reset_n.
- The top level holds detection, counters, overflow and the drop decision.

Test Plan:
- Reset then golden_nonce=0 for 20 cycles -> out_valid=0, found_count=0, drop_count=0.
- golden_nonce 0 -> 0x0000_1234 held 10 cycles, nonce=0x0000_1240, out_ready=1 -> exactly one transfer:
  - out_golden=0x1234, out_nonce=0x1240, out_seq=0.
  - found_count=1.
- out_ready=0; golden_nonce steps 0xA, 0xB, 0xC, 0xD, 0xE, 0xF on consecutive cycles (DEPTH=4) ->
  - 4 entries 0xA..0xD retained; drop_count=2; overflow=1; found_count=6.
  - Draining then yields seq 0, 1, 2, 3 in order.
- FIFO full with out_ready=1 on the same edge as new find 0x77 -> no drop; 0x77 appears last with the correct seq.
- Sequence 0x5 -> 0 -> 0x5 -> two captures; 0x5 held steady afterwards -> no further capture.
- reset_n pulsed low asynchronously mid-cycle with 3 entries buffered -> out_valid drops immediately and all counters read 0. clear with entries buffered -> empty on the next edge, overflow=0.

Source files
------------

// File: rtl/golden_nonce_collector_pkg.sv
// rtl/golden_nonce_collector_pkg.sv - shared widths, entry type and helpers for the nonce collector
package gnc_pkg;

    localparam int GNC_NONCE_W = 32;
    localparam int GNC_CNT_W   = 16;

    typedef struct packed {
        logic [GNC_NONCE_W-1:0] golden;
        logic [GNC_NONCE_W-1:0] nonce;
        logic [GNC_CNT_W-1:0]   seq;
    } entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/golden_nonce_collector_if.sv
// rtl/golden_nonce_collector_if.sv - result stream from the collector to the reporting stage
interface gnc_out_if #(
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 16
);
    logic               out_valid;
    logic               out_ready;
    logic [NONCE_W-1:0] out_golden;
    logic [NONCE_W-1:0] out_nonce;
    logic [CNT_W-1:0]   out_seq;

    modport master (
        output out_valid,
        output out_golden,
        output out_nonce,
        output out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_golden,
        input  out_nonce,
        input  out_seq,
        output out_ready
    );
endinterface

// File: rtl/golden_nonce_collector_fifo.sv
// rtl/golden_nonce_collector_fifo.sv - synchronous FIFO with a registered head entry
module nonce_fifo
    import gnc_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = entry_t
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    input  logic flush,
    output logic full,
    output logic empty,
    output logic head_valid,
    output T     head_data
);

    localparam int AW = clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_next;
    logic [AW:0] rd_next;
    logic        do_push;
    logic        do_pop;
    T            head_next;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_next = do_push ? wr_ptr + 1'b1 : wr_ptr;
        rd_next = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
        // Forward the incoming entry when it lands in the slot that becomes the head.
        if (do_push && (wr_ptr == rd_next)) head_next = push_data;
        else                                head_next = mem[rd_next[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            head_valid <= (wr_next != rd_next);
            head_data  <= head_next;
        end
    end

endmodule

// File: rtl/golden_nonce_collector.sv
// rtl/golden_nonce_collector.sv - captures new golden nonces from the miner into a reporting FIFO
module golden_nonce_collector
    import gnc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NONCE_W = GNC_NONCE_W,
    parameter int CNT_W   = GNC_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NONCE_W-1:0] golden_nonce,
    input  logic [NONCE_W-1:0] nonce,
    input  logic               clear,
    gnc_out_if.master          out,
    output logic [CNT_W-1:0]   found_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               overflow
);

    typedef struct packed {
        logic [NONCE_W-1:0] golden;
        logic [NONCE_W-1:0] nonce;
        logic [CNT_W-1:0]   seq;
    } entry_w_t;

    logic [NONCE_W-1:0] last_seen;
    logic               new_find;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic               head_valid;
    entry_w_t           push_data;
    entry_w_t           head_data;

    assign new_find  = (golden_nonce != '0) && (golden_nonce != last_seen);
    assign push      = new_find && !clear;
    assign pop       = out.out_ready && !empty;
    assign drop      = push && full && !pop;
    assign push_data = '{golden: golden_nonce, nonce: nonce, seq: found_count};

    nonce_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_w_t)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (clear),
        .full       (full),
        .empty      (empty),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign out.out_valid  = head_valid;
    assign out.out_golden = head_data.golden;
    assign out.out_nonce  = head_data.nonce;
    assign out.out_seq    = head_data.seq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_seen   <= '0;
            found_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            last_seen <= golden_nonce;
            if (clear) begin
                found_count <= '0;
                drop_count  <= '0;
                overflow    <= 1'b0;
            end else begin
                // Every find consumes a sequence number, even one that is dropped.
                if (new_find) found_count <= found_count + 1'b1;
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_count != '1) drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_golden_nonce_collector.sv
// tb/tb_golden_nonce_collector.sv - directed self-checking bench for golden_nonce_collector
module tb_golden_nonce_collector;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] golden_nonce = '0;
    logic [31:0] nonce = '0;
    logic [15:0] found_count;
    logic [15:0] drop_count;
    logic        overflow;
    int          errors = 0;
    int          checks = 0;

    gnc_out_if #(.NONCE_W(32), .CNT_W(16)) out_if ();

    golden_nonce_collector #(
        .DEPTH   (4),
        .NONCE_W (32),
        .CNT_W   (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .golden_nonce (golden_nonce),
        .nonce        (nonce),
        .clear        (clear),
        .out          (out_if),
        .found_count  (found_count),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        golden_nonce = '0;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        out_if.out_ready = 1'b0;
        #12;
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_if.out_valid); end
        checks++; if (found_count !== 16'd0) begin errors++; $display("FAIL reset_found: got %0d expected 0", found_count); end
        checks++; if (out_if.out_golden !== 32'd0) begin errors++; $display("FAIL reset_golden: got %h expected 0", out_if.out_golden); end
        reset_n = 1'b1;
        repeat (20) step();
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", out_if.out_valid); end
        checks++; if (found_count !== 16'd0) begin errors++; $display("FAIL idle_found: got %0d expected 0", found_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL idle_drop: got %0d expected 0", drop_count); end
    endtask

    task automatic test_single();
        int          xfers;
        logic [31:0] g;
        logic [31:0] n;
        logic [15:0] s;
        xfers = 0; g = '0; n = '0; s = '1;
        nonce = 32'h0000_1240;
        out_if.out_ready = 1'b1;
        golden_nonce = 32'h0000_1234;
        repeat (10) begin
            step();
            if (out_if.out_valid) begin
                xfers++;
                g = out_if.out_golden;
                n = out_if.out_nonce;
                s = out_if.out_seq;
            end
        end
        checks++; if (xfers !== 1) begin errors++; $display("FAIL single_xfers: got %0d expected 1", xfers); end
        checks++; if (g !== 32'h1234) begin errors++; $display("FAIL single_golden: got %h expected 1234", g); end
        checks++; if (n !== 32'h1240) begin errors++; $display("FAIL single_nonce: got %h expected 1240", n); end
        checks++; if (s !== 16'd0) begin errors++; $display("FAIL single_seq: got %0d expected 0", s); end
        checks++; if (found_count !== 16'd1) begin errors++; $display("FAIL single_found: got %0d expected 1", found_count); end
        out_if.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back_overflow();
        out_if.out_ready = 1'b0;
        do_clear();
        checks++; if (found_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_clear: got found=%0d ovf=%b expected 0 0", found_count, overflow); end
        for (int i = 0; i < 6; i++) begin
            golden_nonce = 32'hA + i;
            step();
        end
        checks++; if (found_count !== 16'd6) begin errors++; $display("FAIL b2b_found: got %0d expected 6", found_count); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL b2b_drop: got %0d expected 2", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow: got %b expected 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1", i, out_if.out_valid); end
            checks++; if (out_if.out_golden !== 32'hA + i) begin errors++; $display("FAIL b2b_golden%0d: got %h expected %h", i, out_if.out_golden, 32'hA + i); end
            checks++; if (out_if.out_seq !== 16'(i)) begin errors++; $display("FAIL b2b_seq%0d: got %0d expected %0d", i, out_if.out_seq, i); end
            out_if.out_ready = 1'b1;
            step();
            out_if.out_ready = 1'b0;
        end
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_if.out_valid); end
    endtask

    task automatic test_full_pop();
        logic [31:0] eg [4];
        logic [15:0] es [4];
        eg[0] = 32'h2; eg[1] = 32'h3; eg[2] = 32'h4; eg[3] = 32'h77;
        es[0] = 16'd1; es[1] = 16'd2; es[2] = 16'd3; es[3] = 16'd4;
        out_if.out_ready = 1'b0;
        do_clear();
        for (int i = 1; i <= 4; i++) begin
            golden_nonce = 32'(i);
            step();
        end
        golden_nonce = 32'h77;
        out_if.out_ready = 1'b1;
        step();
        out_if.out_ready = 1'b0;
        checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_nodrop: got drop=%0d ovf=%b expected 0 0", drop_count, overflow); end
        checks++; if (found_count !== 16'd5) begin errors++; $display("FAIL fullpop_found: got %0d expected 5", found_count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_if.out_valid !== 1'b1 || out_if.out_golden !== eg[i] || out_if.out_seq !== es[i]) begin
                errors++; $display("FAIL fullpop_entry%0d: got v=%b g=%h s=%0d expected v=1 g=%h s=%0d", i, out_if.out_valid, out_if.out_golden, out_if.out_seq, eg[i], es[i]);
            end
            out_if.out_ready = 1'b1;
            step();
            out_if.out_ready = 1'b0;
        end
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b expected 0", out_if.out_valid); end
    endtask

    task automatic test_repeat_value();
        out_if.out_ready = 1'b0;
        do_clear();
        golden_nonce = 32'h5; step();
        golden_nonce = 32'h0; step();
        golden_nonce = 32'h5; step();
        repeat (5) step();
        checks++; if (found_count !== 16'd2) begin errors++; $display("FAIL repeat_found: got %0d expected 2", found_count); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_if.out_valid !== 1'b1 || out_if.out_golden !== 32'h5 || out_if.out_seq !== 16'(i)) begin
                errors++; $display("FAIL repeat_entry%0d: got v=%b g=%h s=%0d expected v=1 g=5 s=%0d", i, out_if.out_valid, out_if.out_golden, out_if.out_seq, i);
            end
            out_if.out_ready = 1'b1;
            step();
            out_if.out_ready = 1'b0;
        end
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL repeat_empty: got %b expected 0", out_if.out_valid); end
    endtask

    task automatic test_async_reset();
        out_if.out_ready = 1'b0;
        do_clear();
        golden_nonce = 32'h21; step();
        golden_nonce = 32'h22; step();
        golden_nonce = 32'h23; step();
        checks++; if (found_count !== 16'd3 || out_if.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got found=%0d v=%b expected 3 1", found_count, out_if.out_valid); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", out_if.out_valid); end
        checks++; if (found_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL arst_counters: got found=%0d drop=%0d ovf=%b expected 0 0 0", found_count, drop_count, overflow);
        end
        checks++; if (out_if.out_golden !== 32'd0 || out_if.out_seq !== 16'd0) begin errors++; $display("FAIL arst_head: got g=%h s=%0d expected 0 0", out_if.out_golden, out_if.out_seq); end
        golden_nonce = '0;
        @(posedge clk);
        #3;
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL arst_hold: got %b expected 0", out_if.out_valid); end
        reset_n = 1'b1;
        step();
        checks++; if (out_if.out_valid !== 1'b0 || found_count !== 16'd0) begin errors++; $display("FAIL arst_after: got v=%b found=%0d expected 0 0", out_if.out_valid, found_count); end
    endtask

    task automatic test_clear();
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            golden_nonce = 32'h31 + i;
            step();
        end
        checks++; if (overflow !== 1'b1 || drop_count !== 16'd1) begin errors++; $display("FAIL clear_pre: got ovf=%b drop=%0d expected 1 1", overflow, drop_count); end
        golden_nonce = 32'h36;
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", out_if.out_valid); end
        checks++; if (found_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL clear_counters: got found=%0d drop=%0d ovf=%b expected 0 0 0", found_count, drop_count, overflow);
        end
        step();
        checks++; if (found_count !== 16'd0 || out_if.out_valid !== 1'b0) begin errors++; $display("FAIL clear_lastseen: got found=%0d v=%b expected 0 0", found_count, out_if.out_valid); end
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back_overflow();
        test_full_pop();
        test_repeat_value();
        test_async_reset();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
